// File: rtl/mul_scale_arbiter.sv
// Round-robin front end for one shared multiplier and scaling shifter.
// Each accepted request is multiplied, shifted right and saturated, then held until the consumer takes it.
module mul_scale_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 4,
  parameter int ID_W    = 2
) (
  input  logic                       ipClk,
  input  logic                       ipReset,
  input  logic [NUM_REQ-1:0]         ipValid,
  output logic [NUM_REQ-1:0]         opReady,
  input  logic [NUM_REQ*WIDTH-1:0]   ipA,
  input  logic [NUM_REQ*WIDTH-1:0]   ipB,
  input  logic [NUM_REQ-1:0]         ipASigned,
  input  logic [NUM_REQ-1:0]         ipBSigned,
  input  logic [NUM_REQ*SHIFT_W-1:0] ipShift,
  output logic                       opResultValid,
  input  logic                       ipResultReady,
  output logic [2*WIDTH-1:0]         opResult,
  output logic [WIDTH-1:0]           opNarrow,
  output logic                       opSaturated,
  output logic                       opResultSigned,
  output logic [ID_W-1:0]            opResultId
);

  typedef enum logic [1:0] {IDLE, MUL, SCALE, OUT} state_t;

  state_t               state;
  logic [ID_W-1:0]      ptr;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 a_signed_q, b_signed_q, signed_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic [ID_W-1:0]      id_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_any;

  // First valid requester after the pointer, wrapping around.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_any && ipValid[(int'(ptr) + k) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        grant_id  = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  assign opReady = (state == IDLE && ipReset) ? grant : '0;

  // Extending to the full product width makes the low 2*WIDTH bits exact for every sign mix.
  logic [2*WIDTH-1:0] a_wide, b_wide;
  assign a_wide = {{WIDTH{a_signed_q & a_q[WIDTH-1]}}, a_q};
  assign b_wide = {{WIDTH{b_signed_q & b_q[WIDTH-1]}}, b_q};

  logic signed [2*WIDTH-1:0] product_s;
  logic [2*WIDTH-1:0]        shift_arith, shift_logic, shifted;
  assign product_s   = product_q;
  assign shift_arith = product_s >>> shift_q;
  assign shift_logic = product_q >> shift_q;
  assign shifted     = signed_q ? shift_arith : shift_logic;

  logic             fits, sat_c;
  logic [WIDTH-1:0] narrow_c;
  always_comb begin
    if (signed_q)
      fits = (&shifted[2*WIDTH-1:WIDTH-1]) | ~(|shifted[2*WIDTH-1:WIDTH-1]);
    else
      fits = ~(|shifted[2*WIDTH-1:WIDTH]);
    sat_c = ~fits;
    if (fits)
      narrow_c = shifted[WIDTH-1:0];
    else if (!signed_q)
      narrow_c = '1;
    else if (shifted[2*WIDTH-1])
      narrow_c = {1'b1, {(WIDTH-1){1'b0}}};
    else
      narrow_c = {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state          <= IDLE;
      ptr            <= ID_W'(NUM_REQ - 1);
      a_q            <= '0;
      b_q            <= '0;
      a_signed_q     <= 1'b0;
      b_signed_q     <= 1'b0;
      signed_q       <= 1'b0;
      shift_q        <= '0;
      id_q           <= '0;
      product_q      <= '0;
      opResultValid  <= 1'b0;
      opResult       <= '0;
      opNarrow       <= '0;
      opSaturated    <= 1'b0;
      opResultSigned <= 1'b0;
      opResultId     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            a_q        <= ipA[int'(grant_id)*WIDTH +: WIDTH];
            b_q        <= ipB[int'(grant_id)*WIDTH +: WIDTH];
            a_signed_q <= ipASigned[grant_id];
            b_signed_q <= ipBSigned[grant_id];
            signed_q   <= ipASigned[grant_id] | ipBSigned[grant_id];
            shift_q    <= ipShift[int'(grant_id)*SHIFT_W +: SHIFT_W];
            id_q       <= grant_id;
            ptr        <= grant_id;
            state      <= MUL;
          end
        end
        MUL: begin
          product_q <= a_wide * b_wide;
          state     <= SCALE;
        end
        SCALE: begin
          opResult       <= shifted;
          opNarrow       <= narrow_c;
          opSaturated    <= sat_c;
          opResultSigned <= signed_q;
          opResultId     <= id_q;
          opResultValid  <= 1'b1;
          state          <= OUT;
        end
        OUT: begin
          if (ipResultReady) begin
            opResultValid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
